// File: rtl/watch_ctrl.sv
// Mode/position controller for the min/sec/hour alarm watch: button edges and ticks
// become registered counter enables, a setup blink flag and the ring/snooze alarm FSM.
module watch_ctrl #(
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10,
  parameter int unsigned BLINK_TICKS  = 25,
  parameter int unsigned RING_SEC     = 30,
  parameter int unsigned SNOOZE_SEC   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sw3,
  input  logic       i_tick_1hz,
  input  logic       i_tick_100hz,
  input  logic       i_sec_max,
  input  logic       i_min_max,
  input  logic       i_alarm_match,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_alarm_en,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic       o_alarm_sec_inc,
  output logic       o_alarm_min_inc,
  output logic       o_alarm_hour_inc,
  output logic       o_blink,
  output logic       o_buzz_en,
  output logic [1:0] alarm_state
);

  typedef enum logic [1:0] {A_IDLE = 2'd0, A_RING = 2'd1, A_SNOOZE = 2'd2} alarm_t;

  localparam logic [1:0] M_CLOCK = 2'd0, M_SETUP = 2'd1, M_ALARM = 2'd2;
  localparam logic [1:0] P_SEC = 2'd0, P_MIN = 2'd1, P_HOUR = 2'd2;
  localparam logic [7:0] HOLD_L   = 8'(HOLD_TICKS);
  localparam logic [7:0] REP_L    = 8'(REPEAT_TICKS);
  localparam logic [7:0] BLINK_L  = 8'(BLINK_TICKS);
  localparam logic [7:0] RING_L   = 8'(RING_SEC);
  localparam logic [7:0] SNOOZE_L = 8'(SNOOZE_SEC);

  logic       prev0, prev1, prev2, prev3, prev_match;
  logic       e0, e1, e2, e3, match_rise;
  logic       step, pos_evt;
  logic       hold_rep_q, hold_rep_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_d;
  logic [1:0] mode_d, pos_d;
  logic       sec_d, min_d, hour_d, asec_d, amin_d, ahour_d;
  alarm_t     state_q, state_d;
  logic [7:0] sec_cnt_q, sec_cnt_d;
  logic       alarm_en_d;

  assign e0         = i_sw0 & ~prev0;
  assign e1         = i_sw1 & ~prev1;
  assign e2         = i_sw2 & ~prev2;
  assign e3         = i_sw3 & ~prev3;
  assign match_rise = i_alarm_match & ~prev_match;
  assign alarm_state = state_q;

  // Step source: press edge, then first repeat after HOLD ticks, then every REPEAT ticks.
  always_comb begin
    step       = e2;
    hold_cnt_d = hold_cnt_q;
    hold_rep_d = hold_rep_q;
    if (!i_sw2) begin
      hold_cnt_d = 8'd0;
      hold_rep_d = 1'b0;
    end else if (i_tick_100hz) begin
      if (hold_cnt_q + 8'd1 == (hold_rep_q ? REP_L : HOLD_L)) begin
        step       = 1'b1;
        hold_cnt_d = 8'd0;
        hold_rep_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 8'd1;
      end
    end
  end

  // sw0 has priority over sw1; sw1 is the snooze key while ringing.
  always_comb begin
    mode_d  = o_mode;
    pos_d   = o_position;
    pos_evt = 1'b0;
    if (e0) begin
      mode_d = (o_mode == M_ALARM) ? M_CLOCK : o_mode + 2'd1;
      pos_d  = P_SEC;
    end else if (e1 && state_q != A_RING) begin
      pos_evt = 1'b1;
      pos_d   = (o_position == P_HOUR) ? P_SEC : o_position + 2'd1;
    end
  end

  always_comb begin
    blink_d     = o_blink;
    blink_cnt_d = blink_cnt_q;
    if (o_mode == M_CLOCK || e0 || pos_evt || step) begin
      blink_d     = 1'b0;
      blink_cnt_d = 8'd0;
    end else if (i_tick_100hz) begin
      if (blink_cnt_q + 8'd1 == BLINK_L) begin
        blink_d     = ~o_blink;
        blink_cnt_d = 8'd0;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    sec_d   = 1'b0;
    min_d   = 1'b0;
    hour_d  = 1'b0;
    asec_d  = 1'b0;
    amin_d  = 1'b0;
    ahour_d = 1'b0;
    if (o_mode == M_SETUP) begin
      sec_d  = step & (o_position == P_SEC);
      min_d  = step & (o_position == P_MIN);
      hour_d = step & (o_position == P_HOUR);
    end else begin
      sec_d  = i_tick_1hz;
      min_d  = i_tick_1hz & i_sec_max;
      hour_d = i_tick_1hz & i_sec_max & i_min_max;
      if (o_mode == M_ALARM) begin
        asec_d  = step & (o_position == P_SEC);
        amin_d  = step & (o_position == P_MIN);
        ahour_d = step & (o_position == P_HOUR);
      end
    end
  end

  // Alarm FSM; sec_cnt is the ring timer in RING and the snooze timer in SNOOZE.
  always_comb begin
    state_d    = state_q;
    sec_cnt_d  = sec_cnt_q;
    alarm_en_d = o_alarm_en;
    case (state_q)
      A_IDLE: begin
        if (e3) begin
          alarm_en_d = ~o_alarm_en;
        end else if (match_rise && o_alarm_en) begin
          state_d   = A_RING;
          sec_cnt_d = 8'd0;
        end
      end
      A_RING: begin
        if (e3) begin
          state_d = A_IDLE;
        end else if (e1) begin
          state_d   = A_SNOOZE;
          sec_cnt_d = 8'd0;
        end else if (i_tick_1hz) begin
          if (sec_cnt_q + 8'd1 == RING_L) state_d = A_IDLE;
          else sec_cnt_d = sec_cnt_q + 8'd1;
        end
      end
      A_SNOOZE: begin
        if (e3) begin
          state_d = A_IDLE;
        end else if (i_tick_1hz) begin
          if (sec_cnt_q + 8'd1 == SNOOZE_L) begin
            state_d   = A_RING;
            sec_cnt_d = 8'd0;
          end else begin
            sec_cnt_d = sec_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = A_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= A_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev0            <= 1'b0;
      prev1            <= 1'b0;
      prev2            <= 1'b0;
      prev3            <= 1'b0;
      prev_match       <= 1'b0;
      hold_cnt_q       <= 8'd0;
      hold_rep_q       <= 1'b0;
      blink_cnt_q      <= 8'd0;
      sec_cnt_q        <= 8'd0;
      o_mode           <= M_CLOCK;
      o_position       <= P_SEC;
      o_alarm_en       <= 1'b0;
      o_blink          <= 1'b0;
      o_buzz_en        <= 1'b0;
      o_sec_inc        <= 1'b0;
      o_min_inc        <= 1'b0;
      o_hour_inc       <= 1'b0;
      o_alarm_sec_inc  <= 1'b0;
      o_alarm_min_inc  <= 1'b0;
      o_alarm_hour_inc <= 1'b0;
    end else begin
      prev0            <= i_sw0;
      prev1            <= i_sw1;
      prev2            <= i_sw2;
      prev3            <= i_sw3;
      prev_match       <= i_alarm_match;
      hold_cnt_q       <= hold_cnt_d;
      hold_rep_q       <= hold_rep_d;
      blink_cnt_q      <= blink_cnt_d;
      sec_cnt_q        <= sec_cnt_d;
      o_mode           <= mode_d;
      o_position       <= pos_d;
      o_alarm_en       <= alarm_en_d;
      o_blink          <= blink_d;
      o_buzz_en        <= (state_d == A_RING);
      o_sec_inc        <= sec_d;
      o_min_inc        <= min_d;
      o_hour_inc       <= hour_d;
      o_alarm_sec_inc  <= asec_d;
      o_alarm_min_inc  <= amin_d;
      o_alarm_hour_inc <= ahour_d;
    end
  end

endmodule
